f5_sweep_checker: RTL

- Self-checking stimulus/response stage wrapped around the f5 gate pair. It computes s = a'.b two ways: gate-level (res_a) and expression-level (res_b).
- Drives every input minterm into both implementations, samples both outputs and compares them against a golden truth table.
- Reports error count, first failing minterm and pass/fail through a start/busy/done handshake.
- Sits directly upstream (stim feeds a,b) and downstream (consumes s of both variants) of the f5 gates.

---
 rtl/f5_sweep_checker_pkg.sv | 16 +
 rtl/f5_sweep_checker_if.sv | 29 ++
 rtl/f5_minterm_counter.sv | 29 ++
 rtl/f5_sweep_checker.sv | 109 ++++++++++
 4 files changed

// File: rtl/f5_sweep_checker_pkg.sv
// Shared definitions for the f5 sweep checker: FSM encoding, golden truth table, defaults.
// s = a'.b is 1 only at minterm 1 (a=0, b=1).
package f5_sweep_checker_pkg;

    localparam int unsigned N_IN_DEFAULT  = 2;
    localparam int unsigned CNT_W_DEFAULT = 3;
    localparam logic [3:0]  GOLDEN_F5     = 4'b0010;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_e;

endpackage

// File: rtl/f5_sweep_checker_if.sv
// Control/status and gate-facing signals of the f5 sweep checker.
// master = the checker itself, slave = the host/bench that owns start and the gates.
interface f5_sweep_checker_if #(
    parameter int unsigned N_IN  = f5_sweep_checker_pkg::N_IN_DEFAULT,
    parameter int unsigned CNT_W = f5_sweep_checker_pkg::CNT_W_DEFAULT
);

    logic             start;
    logic [N_IN-1:0]  stim;
    logic             res_a;
    logic             res_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic             first_err_valid;
    logic [N_IN-1:0]  first_err_idx;

    modport master (
        input  start, res_a, res_b,
        output stim, busy, done, pass, err_cnt, first_err_valid, first_err_idx
    );

    modport slave (
        output start, res_a, res_b,
        input  stim, busy, done, pass, err_cnt, first_err_valid, first_err_idx
    );

endinterface

// File: rtl/f5_minterm_counter.sv
// Minterm index register with synchronous clear, step enable and a last-minterm flag.
// Shared by the f-function sweep checkers.
module f5_minterm_counter #(
    parameter int unsigned N_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_en,
    output logic [N_IN-1:0] o_idx,
    output logic            o_last
);

    logic [N_IN-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= r_idx + N_IN'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == '1);

endmodule

// File: rtl/f5_sweep_checker.sv
// Sweeps every minterm into both f5 implementations, checks them against GOLDEN and
// reports error count, first failing minterm and pass/fail via start/busy/done.
module f5_sweep_checker
    import f5_sweep_checker_pkg::*;
#(
    parameter int unsigned         N_IN   = N_IN_DEFAULT,
    parameter logic [2**N_IN-1:0]  GOLDEN = GOLDEN_F5,
    parameter int unsigned         CNT_W  = CNT_W_DEFAULT
) (
    input logic                 clk,
    input logic                 rst_n,
    f5_sweep_checker_if.master  io_bus
);

    state_e           r_state;
    state_e           w_state_d;
    logic             w_clr;
    logic             w_inc;
    logic             w_sample;
    logic             w_last;
    logic             w_golden;
    logic             w_fail;
    logic [N_IN-1:0]  w_idx;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_first_valid;
    logic [N_IN-1:0]  r_first_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_clr     = 1'b0;
        w_inc     = 1'b0;
        w_sample  = 1'b0;
        case (r_state)
            StIdle, StDone: begin
                if (io_bus.start) begin
                    w_state_d = StDrive;
                    w_clr     = 1'b1;
                end
            end
            StDrive: begin
                w_state_d = StSample;
            end
            StSample: begin
                w_sample = 1'b1;
                if (w_last) begin
                    w_state_d = StDone;
                end else begin
                    w_state_d = StDrive;
                    w_inc     = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // The index register doubles as the registered stim, so it holds in DONE.
    f5_minterm_counter #(
        .N_IN (N_IN)
    ) u_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_en   (w_inc),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    assign w_golden = GOLDEN[w_idx];
    assign w_fail   = (io_bus.res_a != w_golden) || (io_bus.res_b != w_golden);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt     <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
        end else if (w_clr) begin
            r_err_cnt     <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
        end else if (w_sample && w_fail) begin
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (!r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_idx   <= w_idx;
            end
        end
    end

    assign io_bus.stim            = w_idx;
    assign io_bus.busy            = (r_state == StDrive) || (r_state == StSample);
    assign io_bus.done            = (r_state == StDone);
    assign io_bus.pass            = (r_state == StDone) && (r_err_cnt == '0);
    assign io_bus.err_cnt         = r_err_cnt;
    assign io_bus.first_err_valid = r_first_valid;
    assign io_bus.first_err_idx   = r_first_idx;

endmodule
